seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Parametrised serial pattern detector, the runtime-programmable successor to the fixed-pattern serial detectors in this codebase. It matches a pattern of any length from 1 to `MAX_LEN` bits on a valid-qualified serial bit stream. Overlap versus non-overlap mode is selectable at runtime. It emits a registered one-cycle detect pulse and keeps a saturating match counter. It sits directly behind the deserialiser / line-monitor front end and feeds the status and interrupt logic.

## Interface
- `MAX_LEN`, default 16: maximum pattern length in bits; legal range ≥ 2.
- `CNT_W`, default 16: width of the match counter.
- `LEN_W`, derived as $clog2(MAX_LEN+1): width of `cfg_len`; not for override.

Ports:
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  serial input bit.
- `din_valid`  in  1  `din` is sampled only when this is high.
- `cfg_we`  in  1  one-cycle strobe that loads the configuration inputs.
- `cfg_pattern`  in  MAX_LEN  pattern; bit `cfg_len-1` is the first bit received, bit 0 the last.
- `cfg_len`  in  LEN_W  pattern length.
- `cfg_overlap`  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- `cnt_clr`  in  1  synchronous clear of `match_count`.
- `det`  out  1  one-cycle pulse per match.
- `match_count`  out  CNT_W  saturating count of matches.

## Operation
- Config registers: `pat_q`, `len_q`, `ovl_q`.
  - Reset values: all zero. `len_q`=0 means the block is disabled.
  - Updated only on `cfg_we`. `cfg_*` are don't-care otherwise.
- History `hist_q[MAX_LEN-1:0]`:
  - Newest bit sits at `hist_q[0]`.
  - Fill counter `fill_q` (0..MAX_LEN) counts the valid bits held since the last clear.
- On an accepted bit (`din_valid`=1, `cfg_we`=0):
  - `hist_n = {hist_q[MAX_LEN-2:0], din}`.
  - `fill_n = min(fill_q+1, MAX_LEN)`.
- Match condition, all of:
  - accepted bit;
  - 1 ≤ `len_q` ≤ MAX_LEN;
  - `fill_n` ≥ `len_q`;
  - `hist_n[len_q-1:0] == pat_q[len_q-1:0]`.
  - Bits above `len_q` are masked out of the compare.
- On a match:
  - `det` is set for the next cycle.
  - `match_count` increments, saturating at 2^CNT_W−1.
  - If `ovl_q`=0, `fill_q` is forced to 0, so the matched bits cannot form part of the next match. `hist_q` is still written.
- `cfg_len` of 0 or greater than MAX_LEN: config is accepted, but no match ever fires.
- `cfg_we` asserted:
  - Loads the config registers and clears `hist_q` and `fill_q`.
  - Any `din_valid` in that same cycle is discarded and produces no match.
  - `match_count` is untouched.
- `cnt_clr` asserted:
  - `match_count` becomes 0.
  - If a match occurs in the same cycle, the clear wins (count = 0), but `det` still pulses.
- `din_valid`=0: all state holds, and `det` is 0 in the following cycle.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `det`=0, `match_count`=0.
  - `hist_q`=0, `fill_q`=0.
  - `pat_q`=0, `len_q`=0, `ovl_q`=0.
- Latency: `det` is high in the cycle after the clock edge that samples the final pattern bit. It is high for exactly 1 cycle per match.
- `match_count` updates on that same edge, so it is coincident with `det`.
- Back-to-back matches (overlap mode, valid every cycle) give `det` high on consecutive cycles.
- Config takes effect for the first accepted bit after the `cfg_we` edge.
- Reset asserted mid-stream: all partial history is lost immediately, and a pending `det` is cleared without waiting for a clock.
- No combinational path from any input to any output.

## Test plan
1. len=4, pattern=4'b1011, overlap=1, stream 1,0,1,1,0,1,1 with valid every cycle -> `det` follows bits 4 and 7; `match_count`=2.
2. Same pattern, overlap=0:
   - stream 1,0,1,1,0,1,1 -> a single `det` after bit 4; count=1.
   - stream 1,0,1,1,1,0,1,1 -> `det` after bits 4 and 8.
3. len=2, pattern=2'b11, stream 1,1,1,1 -> overlap=1 gives 3 pulses (after bits 2,3,4); overlap=0 gives 2 pulses (after bits 2,4).
4. len=4, pattern=4'b1011, with `din_valid` low for 3 cycles between every bit -> same match positions as scenario 1; `det` still 1 cycle wide.
5. Mid-stream events:
   - `rst_n` low after bits 1,0,1, then 1 -> no `det`; all outputs 0 during reset.
   - `cfg_we` in the cycle of a would-be final bit -> no match; history cleared.
6. CNT_W=4, pattern 1 (len=1), 20 valid 1s -> `match_count` saturates at 15; `cnt_clr` coincident with a match -> count=0 and `det`=1.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector: pattern/length/overlap loaded via cfg_we,
// registered one-cycle detect pulse and saturating match counter.
module seq_detect_prog #(
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 16,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               din,
   input  logic               din_valid,
   input  logic               cfg_we,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               det,
   output logic [CNT_W-1:0]   match_count
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               det_q, det_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MAX_LEN-1:0] hist_n;
   logic [LEN_W-1:0]   fill_n;
   logic [MAX_LEN-1:0] len_mask;
   logic               accept;
   logic               len_ok;
   logic               match;

   // Compare mask keeps only the low len_q bits of history and pattern.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end
   end

   always_comb begin
      accept = din_valid & ~cfg_we;
      len_ok = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
      hist_n = {hist_q[MAX_LEN-2:0], din};
      fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
      match  = accept && len_ok && (fill_n >= len_q) &&
               ((hist_n & len_mask) == (pat_q & len_mask));
   end

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      ovl_d  = ovl_q;
      hist_d = hist_q;
      fill_d = fill_q;
      det_d  = match;
      cnt_d  = cnt_q;

      if (cfg_we) begin
         pat_d  = cfg_pattern;
         len_d  = cfg_len;
         ovl_d  = cfg_overlap;
         hist_d = '0;
         fill_d = '0;
      end else if (accept) begin
         hist_d = hist_n;
         // Non-overlap mode: matched bits must not seed the next match.
         fill_d = (match && !ovl_q) ? '0 : fill_n;
      end

      if (cnt_clr) begin
         cnt_d = '0;
      end else if (match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q  <= '0;
         len_q  <= '0;
         ovl_q  <= 1'b0;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         pat_q  <= pat_d;
         len_q  <= len_d;
         ovl_q  <= ovl_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
      end
   end

   assign det         = det_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: table of stimulus rows with expected det/count,
// plus hand-written reset, mid-stream config and counter saturation sequences.
module tb_seq_detect_prog;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                din, din_valid, cfg_we, cfg_overlap, cnt_clr;
   logic [MAX_LEN-1:0]  cfg_pattern;
   logic [LEN_W-1:0]    cfg_len;
   logic                det, det4;
   logic [15:0]         match_count;
   logic [3:0]          match_count4;

   int checks = 0;
   int errors = 0;

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .det(det), .match_count(match_count)
   );

   seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
      .det(det4), .match_count(match_count4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic               we;
      logic [MAX_LEN-1:0] pat;
      logic [LEN_W-1:0]   len;
      logic               ovl;
      logic               d;
      logic               v;
      logic               clr;
      logic               edet;
      int                 ecnt;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Drive one cycle of inputs (called #1 after a rising edge), return #1 after the next edge.
   task automatic step(input logic d, input logic v, input logic we, input logic clr);
      din = d; din_valid = v; cfg_we = we; cnt_clr = clr;
      @(posedge clk);
      #1;
      din_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic do_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                         input logic o, input logic clr);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      step(1'b0, 1'b0, 1'b1, clr);
   endtask

   task automatic addc(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input logic o);
      tbl.push_back('{we:1'b1, pat:p, len:l, ovl:o, d:1'b0, v:1'b0, clr:1'b1, edet:1'b0, ecnt:0});
   endtask

   task automatic addb(input logic d, input logic v, input logic edet, input int ecnt);
      tbl.push_back('{we:1'b0, pat:'0, len:'0, ovl:1'b0, d:d, v:v, clr:1'b0, edet:edet, ecnt:ecnt});
   endtask

   initial begin
      logic [MAX_LEN-1:0] full_pat;
      logic [6:0]         s1_bits;
      rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

      // Overlap, len 4, 1011 on 1,0,1,1,0,1,1
      addc(16'h000B, 5'd4, 1'b1);
      addb(1,1,0,0); addb(0,1,0,0); addb(1,1,0,0); addb(1,1,1,1);
      addb(0,1,0,1); addb(1,1,0,1); addb(1,1,1,2);
      // Non-overlap, same stream
      addc(16'h000B, 5'd4, 1'b0);
      addb(1,1,0,0); addb(0,1,0,0); addb(1,1,0,0); addb(1,1,1,1);
      addb(0,1,0,1); addb(1,1,0,1); addb(1,1,0,1);
      // Non-overlap, 1,0,1,1,1,0,1,1
      addc(16'h000B, 5'd4, 1'b0);
      addb(1,1,0,0); addb(0,1,0,0); addb(1,1,0,0); addb(1,1,1,1);
      addb(1,1,0,1); addb(0,1,0,1); addb(1,1,0,1); addb(1,1,1,2);
      // len 2, 11: overlap then non-overlap
      addc(16'h0003, 5'd2, 1'b1);
      addb(1,1,0,0); addb(1,1,1,1); addb(1,1,1,2); addb(1,1,1,3);
      addc(16'h0003, 5'd2, 1'b0);
      addb(1,1,0,0); addb(1,1,1,1); addb(1,1,0,1); addb(1,1,1,2);
      // Gapped stream: three invalid cycles carrying the inverted bit after every bit
      addc(16'h000B, 5'd4, 1'b1);
      s1_bits = 7'b1011011;
      for (int k = 6; k >= 0; k--) begin
         int n;
         n = (k <= 3) ? ((k == 0) ? 2 : 1) : 0;
         addb(s1_bits[k], 1, (k == 3) || (k == 0), n);
         for (int g = 0; g < 3; g++) addb(~s1_bits[k], 0, 0, n);
      end
      // Pattern bits above len are ignored
      addc(16'hFFF3, 5'd2, 1'b1);
      addb(1,1,0,0); addb(1,1,1,1); addb(0,1,0,1);
      // len 0 and len > MAX_LEN never fire
      addc(16'h0000, 5'd0, 1'b1);
      addb(0,1,0,0); addb(1,1,0,0);
      addc(16'hFFFF, 5'd17, 1'b1);
      addb(1,1,0,0); addb(1,1,0,0);
      // Full-length pattern fires only on the 16th bit
      full_pat = 16'hA5C3;
      addc(full_pat, 5'd16, 1'b1);
      for (int k = MAX_LEN - 1; k >= 0; k--) addb(full_pat[k], 1, (k == 0), (k == 0) ? 1 : 0);

      #3;
      chk("reset det", det, 0);
      chk("reset count", match_count, 0);
      chk("reset count4", match_count4, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      // Config is zero after reset: valid bits must not match
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("post-reset disabled det", det, 0);

      foreach (tbl[i]) begin
         cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len; cfg_overlap = tbl[i].ovl;
         step(tbl[i].d, tbl[i].v, tbl[i].we, tbl[i].clr);
         chk($sformatf("row%0d det", i), det, tbl[i].edet);
         chk($sformatf("row%0d count", i), match_count, tbl[i].ecnt);
      end

      // Reset asserted while det is high clears outputs without a clock
      do_cfg(16'h000B, 5'd4, 1'b1, 1'b1);
      step(1,1,0,0); step(0,1,0,0); step(1,1,0,0); step(1,1,0,0);
      chk("pre-reset det", det, 1);
      chk("pre-reset count", match_count, 1);
      rst_n = 1'b0;
      #1;
      chk("async reset det", det, 0);
      chk("async reset count", match_count, 0);
      step(1,1,0,0);
      chk("in-reset det", det, 0);
      chk("in-reset count", match_count, 0);
      rst_n = 1'b1;
      do_cfg(16'h000B, 5'd4, 1'b1, 1'b0);
      step(1,1,0,0);
      chk("after reset bit1 det", det, 0);
      step(0,1,0,0); step(1,1,0,0); step(1,1,0,0);
      chk("after reset fresh match det", det, 1);
      chk("after reset fresh match count", match_count, 1);

      // cfg_we on a would-be final bit: bit dropped, history cleared, count kept
      step(1,1,0,0); step(0,1,0,0); step(1,1,0,0);
      cfg_pattern = 16'h000B; cfg_len = 5'd4; cfg_overlap = 1'b1;
      step(1,1,1,0);
      chk("cfg_we final bit det", det, 0);
      chk("cfg_we keeps count", match_count, 1);
      step(1,1,0,0);
      chk("cfg_we cleared hist det", det, 0);
      step(0,1,0,0); step(1,1,0,0); step(1,1,0,0);
      chk("cfg_we later match det", det, 1);
      chk("cfg_we later match count", match_count, 2);

      // Saturation on the 4-bit counter, then clear coincident with a match
      do_cfg(16'h0001, 5'd1, 1'b0, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         step(1,1,0,0);
         chk($sformatf("sat bit%0d det4", i), det4, 1);
         chk($sformatf("sat bit%0d count4", i), match_count4, (i > 15) ? 15 : i);
      end
      step(1,1,0,1);
      chk("clr with match det4", det4, 1);
      chk("clr with match count4", match_count4, 0);
      chk("clr with match count", match_count, 0);
      step(1,1,0,0);
      chk("after clr count4", match_count4, 1);
      step(1,0,0,0);
      chk("idle det4", det4, 0);
      chk("idle count4", match_count4, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
